pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch/commit controller that owns and sequences the program counter of the 32-bit core. It holds the PC, issues instruction-fetch requests to instruction memory, waits for the datapath to retire each instruction, and selects the next PC among sequential, branch, jump and interrupt-vector sources. It also latches pending interrupts, services them only at instruction boundaries, and supports a halt state.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- IRQ_VECTOR, 32'h0000_0080, PC loaded when an interrupt is taken
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request, held high while waiting
- imem_addr  out  32  fetch address, equals pc
- imem_ready  in  1  instruction memory returns data this cycle
- fetch_valid  out  1  one-cycle pulse: fetched instruction is valid for the datapath
- instr_done  in  1  datapath retires current instruction this cycle
- branch_taken  in  1  retiring instruction is a taken branch
- branch_target  in  32  branch destination
- jump  in  1  retiring instruction is a jump (j/jal/jr)
- jump_target  in  32  jump destination
- irq  in  1  interrupt request, level or pulse
- halt  in  1  stop fetching at next boundary while high
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4 (modulo 2^32)
- epc  out  32  return address saved at last interrupt
- irq_taken  out  1  one-cycle pulse when interrupt vectoring occurs
- halted  out  1  high in HALTED state

## Operation
- States: FETCH, EXEC, HALTED.
- Reset (rst_n=0 at an edge): pc=RESET_VECTOR, epc=0, irq_pending=0, state=FETCH, fetch_valid=0, irq_taken=0. The first request is issued in the cycle after reset deasserts.
- FETCH:
  - imem_req=1 and imem_addr=pc, combinationally from state.
  - When imem_ready=1, fetch_valid pulses in the same cycle and the next state is EXEC.
  - Otherwise the block stays in FETCH with the request held.
- EXEC:
  - imem_req=0.
  - Waits for instr_done. While instr_done=0, pc is held.
  - When instr_done=1, the sequential next PC is chosen by priority: jump → jump_target; else branch_taken → branch_target; else pc_plus4.
  - Then the following are applied in order:
    - If irq_pending or irq is high: epc ← sequential next PC, pc ← IRQ_VECTOR, irq_pending ← 0, irq_taken pulses, next state FETCH.
    - Else if halt: pc ← sequential next PC, next state HALTED.
    - Else: pc ← sequential next PC, next state FETCH.
- HALTED:
  - imem_req=0, halted=1.
  - When halt=0, next state is FETCH.
  - If irq_pending or irq is high while halted, the interrupt is taken on that edge regardless of halt: epc ← pc, pc ← IRQ_VECTOR, irq_taken pulses, next state FETCH.
- irq latching: irq_pending is set on any edge with irq=1 that does not service it. It clears only when the interrupt is taken.
- Targets: bits [1:0] of branch_target and jump_target are forced to 0 when loaded into pc.
- Arithmetic: pc_plus4 = pc + 4, 32-bit, wrapping (32'hFFFF_FFFC → 0).
- Ignored inputs:
  - imem_ready outside FETCH.
  - instr_done outside EXEC.
  - branch_taken, jump and their targets unless instr_done=1 in EXEC.

## Timing
- Fetch latency: fetch_valid occurs in the same cycle imem_ready is first seen high in FETCH. Minimum of 1 cycle from entering FETCH.
- Minimum instruction period is 2 cycles (FETCH with immediate ready, then EXEC with immediate done).
- pc changes only on the edge that closes EXEC with instr_done=1, on an interrupt taken in HALTED, or on reset.
- irq_taken and fetch_valid are single-cycle pulses, registered or decoded from the current cycle as stated; both are 0 during reset.
- Reset mid-fetch: an outstanding request is dropped, and the next request uses RESET_VECTOR.
- Reset has priority over every other input.
- Simultaneous events:
  - jump and branch_taken both high → jump wins.
  - irq and halt both high at done → interrupt wins; halt is re-evaluated at the next boundary.

## Test plan
- Reset then imem_ready tied 1, instr_done tied 1 in EXEC → imem_addr sequence 0x0, 0x4, 0x8, one fetch_valid every 2 cycles.
- imem_ready delayed 3 cycles on the fetch at pc=0x4 → imem_req held high 4 cycles with addr 0x4, and pc is unchanged.
- instr_done with branch_taken=1, branch_target=0x0000_0103 → next fetch at 0x100. With jump=1, jump_target=0x200 and branch_taken=1 simultaneously → next fetch at 0x200.
- irq pulsed one cycle during FETCH at pc=0x10, done without branch → irq_taken pulses, epc=0x14, next fetch at 0x80.
- halt=1 at done at pc=0x20 → halted=1, no imem_req, pc=0x24. Release halt after 5 cycles → fetch at 0x24. Repeat with irq raised while halted → epc=0x24, fetch at 0x80.
- pc=0xFFFF_FFFC, sequential done → pc=0x0. Then assert rst_n=0 during a stalled FETCH → pc=RESET_VECTOR, epc=0, and no fetch_valid.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter of the 32-bit core. Issues instruction fetches,
//   waits for the datapath to retire each instruction, picks the next PC
//   (sequential / branch / jump / interrupt vector), latches interrupts until
//   the next instruction boundary and supports a halt state.
//
// Ports
//   clk, rst_n       core clock, synchronous active-low reset
//   imem_req/addr    fetch request (held while waiting) and address (= pc)
//   imem_ready       instruction memory has data this cycle
//   fetch_valid      one-cycle pulse: fetched instruction is valid
//   instr_done       datapath retires current instruction
//   branch_taken/branch_target, jump/jump_target   redirect of retiring instr
//   irq, halt        interrupt request, halt request
//   pc, pc_plus4     current PC and PC + 4 (wrapping)
//   epc              return address saved at the last interrupt
//   irq_taken        one-cycle pulse after interrupt vectoring
//   halted           high while in HALTED
module pc_sequencer #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [DATA_W-1:0] IRQ_VECTOR   = 32'h0000_0080
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic              fetch_valid,
  input  logic              instr_done,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  input  logic              irq,
  input  logic              halt,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] epc,
  output logic              irq_taken,
  output logic              halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state;
  logic              irq_pending;
  logic [DATA_W-1:0] seq_next;

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return {a[DATA_W-1:2], 2'b00};
  endfunction

  assign pc_plus4 = pc + DATA_W'(4);

  // Redirect priority at retirement: jump over branch over fall-through.
  always_comb begin
    seq_next = pc_plus4;
    if (jump)
      seq_next = word_align(jump_target);
    else if (branch_taken)
      seq_next = word_align(branch_target);
  end

  // Gated by rst_n so an outstanding fetch disappears the moment reset is
  // asserted and nothing is presented to the datapath during reset.
  assign imem_req    = rst_n && (state == FETCH);
  assign imem_addr   = pc;
  assign fetch_valid = rst_n && (state == FETCH) && imem_ready;
  assign halted      = (state == HALTED);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_VECTOR;
      epc         <= '0;
      irq_pending <= 1'b0;
      irq_taken   <= 1'b0;
    end else begin
      irq_taken <= 1'b0;
      // Latch any request; servicing branches below override this with 0.
      if (irq)
        irq_pending <= 1'b1;

      case (state)
        FETCH: begin
          if (imem_ready)
            state <= EXEC;
        end

        EXEC: begin
          if (instr_done) begin
            if (irq_pending || irq) begin
              epc         <= seq_next;
              pc          <= IRQ_VECTOR;
              irq_pending <= 1'b0;
              irq_taken   <= 1'b1;
              state       <= FETCH;
            end else begin
              pc    <= seq_next;
              state <= halt ? HALTED : FETCH;
            end
          end
        end

        HALTED: begin
          // An interrupt wakes the core even while halt is still asserted.
          if (irq_pending || irq) begin
            epc         <= pc;
            pc          <= IRQ_VECTOR;
            irq_pending <= 1'b0;
            irq_taken   <= 1'b1;
            state       <= FETCH;
          end else if (!halt) begin
            state <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        fetch_valid;
  logic        instr_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        irq;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        irq_taken;
  logic        halted;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .fetch_valid  (fetch_valid),
    .instr_done   (instr_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .irq          (irq),
    .halt         (halt),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .epc          (epc),
    .irq_taken    (irq_taken),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_epc[$];
  int          fv_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a fetch or an irq.
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      fv_cyc.push_back(cyc);
      if (exp_fetch.size() == 0) check("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
      else check("fetch_addr", imem_addr, exp_fetch.pop_front());
    end
    if (irq_taken === 1'b1) begin
      if (exp_epc.size() == 0) check("unexpected_irq", epc, 32'hDEAD_BEEF);
      else begin
        check("irq_epc", epc, exp_epc.pop_front());
        check("irq_pc", pc, 32'h0000_0080);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Complete one fetch at addr after 'delay' stalled cycles.
  task automatic fetch(input logic [31:0] addr, input int delay);
    exp_fetch.push_back(addr);
    for (int i = 0; i < delay; i++) begin
      imem_ready = 1'b0;
      sample();
      check("stall_req", 32'(imem_req), 32'd1);
      check("stall_addr", imem_addr, addr);
      check("stall_pc", pc, addr);
      step();
    end
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    irq        = 1'b0;
  endtask

  // Retire one instruction after 'delay' cycles; imem_ready is held high
  // meanwhile and must be ignored. halt is left as given for the caller.
  task automatic exec(input int delay, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt, input logic i,
                      input logic h, input logic exp_irq, input logic [31:0] e);
    logic [31:0] pc_before;
    pc_before = pc;
    for (int k = 0; k < delay; k++) begin
      imem_ready = 1'b1;
      sample();
      check("exec_hold_pc", pc, pc_before);
      step();
    end
    imem_ready    = 1'b0;
    instr_done    = 1'b1;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_target = bt;
    irq           = i;
    halt          = h;
    if (exp_irq) exp_epc.push_back(e);
    step();
    instr_done   = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    irq          = 1'b0;
  endtask

  task automatic seq_exec();
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic jump_exec(input logic [31:0] t);
    exec(0, 1'b1, t, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; instr_done = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    irq = 1'b0; halt = 1'b0;

    // Reset with imem_ready high: no request and no fetch_valid.
    repeat (3) step();
    sample();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_fv", 32'(fetch_valid), 32'd0);
    check("rst_irq_taken", 32'(irq_taken), 32'd0);
    check("rst_pc", pc, 32'h0);
    step();
    rst_n = 1'b1; imem_ready = 1'b0;
    sample();
    check("post_rst_pc", pc, 32'h0);
    check("post_rst_epc", epc, 32'h0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_halted", 32'(halted), 32'd0);
    step();

    // Back-to-back sequential instructions.
    fetch(32'h0, 0); seq_exec();
    fetch(32'h4, 0); seq_exec();
    fetch(32'h8, 0); jump_exec(32'h4);
    sample();
    if (fv_cyc.size() >= 3) begin
      check("fv_period_1", 32'(fv_cyc[1] - fv_cyc[0]), 32'd2);
      check("fv_period_2", 32'(fv_cyc[2] - fv_cyc[1]), 32'd2);
    end else check("fv_count", 32'(fv_cyc.size()), 32'd3);
    step();

    // Stalled fetch at 0x4 (3 wait cycles), then branch with low bits set.
    fetch(32'h4, 3); seq_exec();
    fetch(32'h8, 0);
    exec(0, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(32'h100, 0);
    exec(0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch(32'h200, 0);
    exec(2, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // irq pulsed during FETCH at 0x10 is latched and taken at done.
    irq = 1'b1;
    fetch(32'h10, 0);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h14);
    fetch(32'h80, 0); jump_exec(32'h20);

    // Halt at done, release after 5 cycles.
    fetch(32'h20, 0);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    sample();
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_req", 32'(imem_req), 32'd0);
    check("halt_pc", pc, 32'h24);
    repeat (5) step();
    sample();
    check("halt_hold", 32'(halted), 32'd1);
    step();
    halt = 1'b0;
    step();
    fetch(32'h24, 0); jump_exec(32'h20);

    // Halt again, then wake with irq while halt stays high.
    fetch(32'h20, 0);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    sample();
    check("halt2_halted", 32'(halted), 32'd1);
    step();
    irq = 1'b1;
    exp_epc.push_back(32'h24);
    step();
    irq = 1'b0; halt = 1'b0;
    sample();
    check("wake_halted", 32'(halted), 32'd0);
    check("wake_pc", pc, 32'h80);
    step();

    // Wrap at top of address space (jump target low bits dropped).
    fetch(32'h80, 0); jump_exec(32'hFFFF_FFFF);
    fetch(32'hFFFF_FFFC, 0);
    sample();
    check("wrap_plus4", pc_plus4, 32'h0);
    step();
    seq_exec();
    sample();
    check("wrap_pc", pc, 32'h0);
    step();

    // irq and halt together at done: interrupt wins, no halt.
    fetch(32'h0, 0);
    exec(0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4);
    halt = 1'b0;
    sample();
    check("irq_over_halt", 32'(halted), 32'd0);
    step();
    fetch(32'h80, 0); seq_exec();

    // Reset during a stalled fetch at 0x84.
    imem_ready = 1'b0;
    sample();
    check("pre_rst_req", 32'(imem_req), 32'd1);
    check("pre_rst_addr", imem_addr, 32'h84);
    step();
    rst_n = 1'b0; imem_ready = 1'b1;
    sample();
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_fv", 32'(fetch_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1; imem_ready = 1'b0;
    sample();
    check("midrst_pc", pc, 32'h0);
    check("midrst_epc", epc, 32'h0);
    step();
    fetch(32'h0, 0); seq_exec();

    repeat (2) step();
    sample();
    check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);
    check("epc_queue_empty", 32'(exp_epc.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
